// File: rtl/axil_regbank_pkg.sv
// Shared types for the AXI4-Lite register bank: response codes, FSM states,
// the address-region decode result and the response-selection helper.
package axil_regbank_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} wr_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} rd_state_e;

  typedef enum logic [2:0] {
    REG_RW,
    REG_RO,
    REG_IRQ_STAT,
    REG_IRQ_EN,
    REG_UNMAPPED
  } region_e;

  // Response for an access to a decoded region; writes to RO space are refused.
  function automatic logic [1:0] region_resp(region_e region, logic is_write);
    case (region)
      REG_RO:       return is_write ? RESP_SLVERR : RESP_OKAY;
      REG_UNMAPPED: return RESP_DECERR;
      default:      return RESP_OKAY;
    endcase
  endfunction

endpackage

// File: rtl/axil_regbank_if.sv
// AXI4-Lite bus bundle for the register bank (clock/reset stay outside).
// master: drives addresses, data, strobes, valids and response readies.
// slave : drives address/data readies, responses and read data.
interface axil_regbank_if #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0]   S_AXI_AWADDR;
  logic [2:0]          S_AXI_AWPROT;
  logic                S_AXI_AWVALID;
  logic                S_AXI_AWREADY;
  logic [DATA_W-1:0]   S_AXI_WDATA;
  logic [DATA_W/8-1:0] S_AXI_WSTRB;
  logic                S_AXI_WVALID;
  logic                S_AXI_WREADY;
  logic [1:0]          S_AXI_BRESP;
  logic                S_AXI_BVALID;
  logic                S_AXI_BREADY;
  logic [ADDR_W-1:0]   S_AXI_ARADDR;
  logic [2:0]          S_AXI_ARPROT;
  logic                S_AXI_ARVALID;
  logic                S_AXI_ARREADY;
  logic [DATA_W-1:0]   S_AXI_RDATA;
  logic [1:0]          S_AXI_RRESP;
  logic                S_AXI_RVALID;
  logic                S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB,
           S_AXI_WVALID, S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
           S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID, S_AXI_ARREADY,
           S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB,
           S_AXI_WVALID, S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
           S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID, S_AXI_ARREADY,
           S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/axil_regbank_decode.sv
// Combinational word-index to register-region decoder.
// Ports: idx (word index) in, region (decode result) out.
// With AXIL_REGBANK_IRQ_EN the two IRQ registers follow the RO block.
module axil_regbank_decode
  import axil_regbank_pkg::*;
#(
  parameter int unsigned IDX_W  = 4,
  parameter int unsigned NUM_RW = 4,
  parameter int unsigned NUM_RO = 2
) (
  input  logic [IDX_W-1:0] idx,
  output region_e          region
);
  logic [31:0] idx_ext;
  assign idx_ext = 32'(idx);

  always_comb begin
    region = REG_UNMAPPED;
    if (idx_ext < NUM_RW)               region = REG_RW;
    else if (idx_ext < NUM_RW + NUM_RO) region = REG_RO;
`ifdef AXIL_REGBANK_IRQ_EN
    else if (idx_ext == NUM_RW + NUM_RO)      region = REG_IRQ_STAT;
    else if (idx_ext == NUM_RW + NUM_RO + 1)  region = REG_IRQ_EN;
`endif
  end
endmodule

// File: rtl/axil_regbank.sv
// Parameterised AXI4-Lite register bank: NUM_RW strobed control registers,
// NUM_RO status registers, per-register write pulses, SLVERR/DECERR on
// illegal accesses. Independent 3-state write and read FSMs.
// Ports: ACLK, ARESET (async, active high), s_axi (slave modport),
//   ctrl_o (RW contents, reg k at [k*DW +: DW]), wr_pulse_o, status_i.
// Optional macro AXIL_REGBANK_IRQ_EN adds IRQ_STATUS (W1C) / IRQ_ENABLE
// registers and the irq_src_i / irq_o ports.
module axil_regbank
  import axil_regbank_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 6,
  parameter int unsigned NUM_RW             = 4,
  parameter int unsigned NUM_RO             = 2,
  parameter int unsigned NUM_IRQ            = 8
) (
  input  logic                                 ACLK,
  input  logic                                 ARESET,
  axil_regbank_if.slave                        s_axi,
  output logic [NUM_RW*C_S_AXI_DATA_WIDTH-1:0] ctrl_o,
  output logic [NUM_RW-1:0]                    wr_pulse_o,
  input  logic [((NUM_RO > 0) ? NUM_RO : 1)*C_S_AXI_DATA_WIDTH-1:0] status_i
`ifdef AXIL_REGBANK_IRQ_EN
  ,
  input  logic [NUM_IRQ-1:0]                   irq_src_i,
  output logic                                 irq_o
`endif
);
  localparam int unsigned DW       = C_S_AXI_DATA_WIDTH;
  localparam int unsigned AW       = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned STRB_W   = DW / 8;
  localparam int unsigned ADDR_LSB = $clog2(STRB_W);
  localparam int unsigned IDX_W    = AW - ADDR_LSB;

  wr_state_e               w_state_q, w_state_d;
  rd_state_e               r_state_q, r_state_d;
  logic [IDX_W-1:0]        w_idx_q, r_idx_q;
  logic [DW-1:0]           w_data_q;
  logic [STRB_W-1:0]       w_strb_q;
  logic [DW-1:0]           strb_mask;
  region_e                 w_region, r_region;
  logic                    w_ready_q, w_ready_d, b_valid_q, b_valid_d;
  logic [1:0]              b_resp_q, b_resp_d, r_resp_q, r_resp_d;
  logic                    ar_ready_q, ar_ready_d, r_valid_q, r_valid_d;
  logic [DW-1:0]           r_data_q, r_data_d, rd_word;
  logic [NUM_RW-1:0][DW-1:0] ctrl_q;
  logic [NUM_RW-1:0]       wr_pulse_q;
  logic                    w_commit;
  logic                    unused_bits;

  assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                         s_axi.S_AXI_AWADDR[ADDR_LSB-1:0], s_axi.S_AXI_ARADDR[ADDR_LSB-1:0]};

  axil_regbank_decode #(.IDX_W(IDX_W), .NUM_RW(NUM_RW), .NUM_RO(NUM_RO))
    u_wdec (.idx(w_idx_q), .region(w_region));
  axil_regbank_decode #(.IDX_W(IDX_W), .NUM_RW(NUM_RW), .NUM_RO(NUM_RO))
    u_rdec (.idx(r_idx_q), .region(r_region));

  // Registers are updated in the single W_ACK cycle.
  assign w_commit = (w_state_q == W_ACK);

  always_comb begin
    strb_mask = '0;
    for (int unsigned b = 0; b < STRB_W; b++) strb_mask[b*8 +: 8] = {8{w_strb_q[b]}};
  end

`ifdef AXIL_REGBANK_IRQ_EN
  logic [NUM_IRQ-1:0] irq_src_q, irq_stat_q, irq_en_q, irq_rise, irq_clr;
  logic               irq_q;

  assign irq_rise = irq_src_i & ~irq_src_q;
  assign irq_clr  = (w_commit && w_region == REG_IRQ_STAT) ? NUM_IRQ'(w_data_q & strb_mask) : '0;

  // Edge capture and W1C; a new edge wins over a same-cycle clear.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      irq_src_q  <= '0;
      irq_stat_q <= '0;
      irq_en_q   <= '0;
      irq_q      <= 1'b0;
    end else begin
      irq_src_q  <= irq_src_i;
      irq_stat_q <= (irq_stat_q & ~irq_clr) | irq_rise;
      if (w_commit && w_region == REG_IRQ_EN)
        irq_en_q <= (irq_en_q & ~NUM_IRQ'(strb_mask)) | NUM_IRQ'(w_data_q & strb_mask);
      irq_q      <= |(irq_stat_q & irq_en_q);
    end
  end

  assign irq_o = irq_q;
`endif

  // Write FSM next-state and response outputs.
  always_comb begin
    w_state_d = w_state_q;
    w_ready_d = 1'b0;
    b_valid_d = b_valid_q;
    b_resp_d  = b_resp_q;
    unique case (w_state_q)
      W_IDLE: if (s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID) begin
        w_state_d = W_ACK;
        w_ready_d = 1'b1;
      end
      W_ACK: begin
        w_state_d = W_RESP;
        b_valid_d = 1'b1;
        b_resp_d  = region_resp(w_region, 1'b1);
      end
      W_RESP: if (s_axi.S_AXI_BREADY) begin
        w_state_d = W_IDLE;
        b_valid_d = 1'b0;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write-side state, capture and register update.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      w_state_q  <= W_IDLE;
      w_ready_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      b_resp_q   <= RESP_OKAY;
      w_idx_q    <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      ctrl_q     <= '0;
      wr_pulse_q <= '0;
    end else begin
      w_state_q  <= w_state_d;
      w_ready_q  <= w_ready_d;
      b_valid_q  <= b_valid_d;
      b_resp_q   <= b_resp_d;
      wr_pulse_q <= '0;
      if (w_state_q == W_IDLE && s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID) begin
        w_idx_q  <= s_axi.S_AXI_AWADDR[AW-1:ADDR_LSB];
        w_data_q <= s_axi.S_AXI_WDATA;
        w_strb_q <= s_axi.S_AXI_WSTRB;
      end
      if (w_commit && w_region == REG_RW) begin
        for (int unsigned k = 0; k < NUM_RW; k++) begin
          if (w_idx_q == IDX_W'(k)) begin
            ctrl_q[k]     <= (ctrl_q[k] & ~strb_mask) | (w_data_q & strb_mask);
            wr_pulse_q[k] <= 1'b1;
          end
        end
      end
    end
  end

  // Read data mux; unmapped space reads as zero.
  always_comb begin
    rd_word = '0;
    case (r_region)
      REG_RW:
        for (int unsigned k = 0; k < NUM_RW; k++)
          if (r_idx_q == IDX_W'(k)) rd_word = ctrl_q[k];
      REG_RO:
        for (int unsigned j = 0; j < NUM_RO; j++)
          if (r_idx_q == IDX_W'(NUM_RW + j)) rd_word = status_i[j*DW +: DW];
`ifdef AXIL_REGBANK_IRQ_EN
      REG_IRQ_STAT: rd_word = DW'(irq_stat_q);
      REG_IRQ_EN:   rd_word = DW'(irq_en_q);
`endif
      default:      rd_word = '0;
    endcase
  end

  // Read FSM next-state and data outputs.
  always_comb begin
    r_state_d  = r_state_q;
    ar_ready_d = 1'b0;
    r_valid_d  = r_valid_q;
    r_resp_d   = r_resp_q;
    r_data_d   = r_data_q;
    unique case (r_state_q)
      R_IDLE: if (s_axi.S_AXI_ARVALID) begin
        r_state_d  = R_ACK;
        ar_ready_d = 1'b1;
      end
      R_ACK: begin
        r_state_d = R_DATA;
        r_valid_d = 1'b1;
        r_data_d  = rd_word;
        r_resp_d  = region_resp(r_region, 1'b0);
      end
      R_DATA: if (s_axi.S_AXI_RREADY) begin
        r_state_d = R_IDLE;
        r_valid_d = 1'b0;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state_q  <= R_IDLE;
      ar_ready_q <= 1'b0;
      r_valid_q  <= 1'b0;
      r_resp_q   <= RESP_OKAY;
      r_data_q   <= '0;
      r_idx_q    <= '0;
    end else begin
      r_state_q  <= r_state_d;
      ar_ready_q <= ar_ready_d;
      r_valid_q  <= r_valid_d;
      r_resp_q   <= r_resp_d;
      r_data_q   <= r_data_d;
      if (r_state_q == R_IDLE && s_axi.S_AXI_ARVALID)
        r_idx_q <= s_axi.S_AXI_ARADDR[AW-1:ADDR_LSB];
    end
  end

  assign s_axi.S_AXI_AWREADY = w_ready_q;
  assign s_axi.S_AXI_WREADY  = w_ready_q;
  assign s_axi.S_AXI_BVALID  = b_valid_q;
  assign s_axi.S_AXI_BRESP   = b_resp_q;
  assign s_axi.S_AXI_ARREADY = ar_ready_q;
  assign s_axi.S_AXI_RVALID  = r_valid_q;
  assign s_axi.S_AXI_RRESP   = r_resp_q;
  assign s_axi.S_AXI_RDATA   = r_data_q;
  assign ctrl_o              = ctrl_q;
  assign wr_pulse_o          = wr_pulse_q;
endmodule

// File: tb/tb_axil_regbank.sv
// Bench for axil_regbank (default parameters): directed register-map cases
// plus a randomized read/write mix, checked against an array-based model.
module tb_axil_regbank;
  localparam int NUM_RW = 4;
  localparam int NUM_RO = 2;

  logic         ACLK;
  logic         ARESET;
  logic [127:0] ctrl;
  logic [3:0]   wr_pulse;
  logic [63:0]  status;
`ifdef AXIL_REGBANK_IRQ_EN
  logic [7:0]   irq_src;
  logic         irq;
`endif

  axil_regbank_if #(.ADDR_W(6), .DATA_W(32)) bus ();

  axil_regbank dut (
    .ACLK       (ACLK),
    .ARESET     (ARESET),
    .s_axi      (bus),
    .ctrl_o     (ctrl),
    .wr_pulse_o (wr_pulse),
    .status_i   (status)
`ifdef AXIL_REGBANK_IRQ_EN
    ,
    .irq_src_i  (irq_src),
    .irq_o      (irq)
`endif
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference state: RW register contents and IRQ registers.
  logic [31:0] m_ctrl [NUM_RW];
  logic [7:0]  m_irq_stat;
  logic [7:0]  m_irq_en;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // 0 = RW, 1 = RO, 2 = IRQ status, 3 = IRQ enable, 4 = unmapped
  function automatic int region_of(input int idx);
    if (idx < NUM_RW) return 0;
    if (idx < NUM_RW + NUM_RO) return 1;
`ifdef AXIL_REGBANK_IRQ_EN
    if (idx == NUM_RW + NUM_RO) return 2;
    if (idx == NUM_RW + NUM_RO + 1) return 3;
`endif
    return 4;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NUM_RW; k++) m_ctrl[k] = '0;
    m_irq_stat = '0;
    m_irq_en   = '0;
  endtask

  task automatic check_ctrl(input string tag);
    for (int k = 0; k < NUM_RW; k++) check(tag, ctrl[k*32 +: 32], m_ctrl[k]);
  endtask

  task automatic do_write(input int idx, input logic [31:0] data, input logic [3:0] strb,
                          input int w_dly, input int b_dly, input bit edge_at_ack);
    logic [1:0]  exp_resp;
    logic [3:0]  exp_pulse;
    logic [31:0] mask;
    int          reg_kind;
    reg_kind = region_of(idx);
    mask = '0;
    for (int b = 0; b < 4; b++) if (strb[b]) mask[b*8 +: 8] = 8'hFF;
    bus.S_AXI_AWADDR  = 6'(idx * 4 + int'($urandom_range(0, 3)));
    bus.S_AXI_WDATA   = data;
    bus.S_AXI_WSTRB   = strb;
    bus.S_AXI_AWVALID = 1'b1;
    for (int i = 0; i < w_dly; i++) begin
      tick();
      check("awready_wait", bus.S_AXI_AWREADY, 1'b0);
      check("wready_wait", bus.S_AXI_WREADY, 1'b0);
    end
    bus.S_AXI_WVALID = 1'b1;
    tick();
    check("awready", bus.S_AXI_AWREADY, 1'b1);
    check("wready", bus.S_AXI_WREADY, 1'b1);
`ifdef AXIL_REGBANK_IRQ_EN
    if (edge_at_ack) irq_src[0] = 1'b1;
`endif
    tick();
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    check("awready_once", bus.S_AXI_AWREADY, 1'b0);
    exp_pulse = '0;
    case (reg_kind)
      0: begin
        exp_resp  = 2'b00;
        exp_pulse = 4'(1 << idx);
        m_ctrl[idx] = (m_ctrl[idx] & ~mask) | (data & mask);
      end
      1: exp_resp = 2'b10;
      2: begin
        exp_resp   = 2'b00;
        m_irq_stat = m_irq_stat & ~8'(data & mask);
        if (edge_at_ack) m_irq_stat[0] = 1'b1;
      end
      3: begin
        exp_resp = 2'b00;
        m_irq_en = (m_irq_en & ~8'(mask)) | 8'(data & mask);
      end
      default: exp_resp = 2'b11;
    endcase
    check("bvalid", bus.S_AXI_BVALID, 1'b1);
    check("bresp", bus.S_AXI_BRESP, exp_resp);
    check("wr_pulse", wr_pulse, exp_pulse);
    check_ctrl("ctrl_after_wr");
    for (int i = 0; i < b_dly; i++) begin
      tick();
      check("bvalid_hold", bus.S_AXI_BVALID, 1'b1);
      check("bresp_hold", bus.S_AXI_BRESP, exp_resp);
    end
    bus.S_AXI_BREADY = 1'b1;
    tick();
    bus.S_AXI_BREADY = 1'b0;
    check("bvalid_done", bus.S_AXI_BVALID, 1'b0);
    check("wr_pulse_clr", wr_pulse, 4'h0);
  endtask

  task automatic do_read(input int idx, input int r_dly);
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    status = {$urandom, $urandom};
    bus.S_AXI_ARADDR  = 6'(idx * 4 + int'($urandom_range(0, 3)));
    bus.S_AXI_ARVALID = 1'b1;
    tick();
    check("arready", bus.S_AXI_ARREADY, 1'b1);
    exp_resp = 2'b00;
    case (region_of(idx))
      0: exp_data = m_ctrl[idx];
      1: exp_data = status[(idx - NUM_RW) * 32 +: 32];
      2: exp_data = 32'(m_irq_stat);
      3: exp_data = 32'(m_irq_en);
      default: begin
        exp_data = '0;
        exp_resp = 2'b11;
      end
    endcase
    tick();
    bus.S_AXI_ARVALID = 1'b0;
    check("arready_once", bus.S_AXI_ARREADY, 1'b0);
    check("rvalid", bus.S_AXI_RVALID, 1'b1);
    check("rdata", bus.S_AXI_RDATA, exp_data);
    check("rresp", bus.S_AXI_RRESP, exp_resp);
    for (int i = 0; i < r_dly; i++) begin
      tick();
      check("rvalid_hold", bus.S_AXI_RVALID, 1'b1);
      check("rdata_hold", bus.S_AXI_RDATA, exp_data);
    end
    bus.S_AXI_RREADY = 1'b1;
    tick();
    bus.S_AXI_RREADY = 1'b0;
    check("rvalid_done", bus.S_AXI_RVALID, 1'b0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_awready"}, bus.S_AXI_AWREADY, 1'b0);
    check({tag, "_wready"}, bus.S_AXI_WREADY, 1'b0);
    check({tag, "_bvalid"}, bus.S_AXI_BVALID, 1'b0);
    check({tag, "_bresp"}, bus.S_AXI_BRESP, 2'b00);
    check({tag, "_arready"}, bus.S_AXI_ARREADY, 1'b0);
    check({tag, "_rvalid"}, bus.S_AXI_RVALID, 1'b0);
    check({tag, "_rresp"}, bus.S_AXI_RRESP, 2'b00);
    check({tag, "_rdata"}, bus.S_AXI_RDATA, 32'h0);
    check({tag, "_ctrl"}, ctrl[63:0] | ctrl[127:64], 64'h0);
    check({tag, "_pulse"}, wr_pulse, 4'h0);
  endtask

  initial begin
    int idx;
    ARESET = 1'b1;
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA  = '0; bus.S_AXI_WSTRB  = '0; bus.S_AXI_WVALID  = 1'b0;
    bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b0;
    status = '0;
`ifdef AXIL_REGBANK_IRQ_EN
    irq_src = '0;
`endif
    model_reset();
    repeat (3) tick();
    check_idle_outputs("reset");
    ARESET = 1'b0;
    tick();
    check_idle_outputs("post_reset");

    // Sequential writes and read-back.
    for (int k = 0; k < 4; k++) do_write(k, 32'(k + 1), 4'hF, 0, 0, 1'b0);
    for (int k = 0; k < 4; k++) do_read(k, 0);

    // Byte strobes.
    do_write(0, 32'hAABBCCDD, 4'hF, 0, 0, 1'b0);
    do_write(0, 32'h11223344, 4'b0101, 0, 0, 1'b0);
    check("strb_merge", ctrl[31:0], 32'hAA22CC44);

    // Error responses: RO write, unmapped read, unmapped write.
    do_write(4, 32'h0000FFFF, 4'hF, 0, 0, 1'b0);
    do_read(4, 1);
    do_read(15, 0);
    do_write(15, 32'h12345678, 4'hF, 0, 0, 1'b0);

    // Handshake skew and response back-pressure.
    do_write(2, 32'hCAFEF00D, 4'hF, 5, 4, 1'b0);
    do_read(2, 3);

    // Reset while the write response is pending.
    bus.S_AXI_AWADDR = 6'h04; bus.S_AXI_WDATA = 32'hDEAD0001; bus.S_AXI_WSTRB = 4'hF;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
    tick();
    tick();
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    check("mid_rst_bvalid_pre", bus.S_AXI_BVALID, 1'b1);
    #2 ARESET = 1'b1;
    #1;
    check("mid_rst_bvalid", bus.S_AXI_BVALID, 1'b0);
    check("mid_rst_ctrl", ctrl, 128'h0);
    model_reset();
    @(posedge ACLK);
    #1 ARESET = 1'b0;
    tick();
    check_idle_outputs("mid_rst_idle");
    do_write(1, 32'h0BADBEEF, 4'hF, 0, 0, 1'b0);
    do_read(1, 0);

`ifdef AXIL_REGBANK_IRQ_EN
    // IRQ: enable bit 0, raise source 0.
    do_write(7, 32'h1, 4'hF, 0, 0, 1'b0);
    check("irq_idle", irq, 1'b0);
    irq_src[0] = 1'b1;
    tick();
    tick();
    irq_src[0] = 1'b0;
    m_irq_stat[0] = 1'b1;
    check("irq_set", irq, 1'b1);
    do_read(6, 0);
    do_write(6, 32'h1, 4'hF, 0, 0, 1'b1);
    irq_src[0] = 1'b0;
    do_read(6, 0);
    check("irq_set_wins", irq, 1'b1);
    do_write(6, 32'h1, 4'hF, 0, 0, 1'b0);
    do_read(6, 0);
    check("irq_cleared", irq, 1'b0);
    do_read(7, 0);
`endif

    // Randomized mix against the model.
    for (int n = 0; n < 60; n++) begin
      idx = int'($urandom_range(0, 15));
`ifdef AXIL_REGBANK_IRQ_EN
      if (idx == 6 || idx == 7) idx = 12;
`endif
      if ($urandom_range(0, 1) == 1)
        do_write(idx, $urandom, 4'($urandom), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), 1'b0);
      else
        do_read(idx, int'($urandom_range(0, 3)));
    end
    check_ctrl("ctrl_final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/axil_regbank.md
Name: axil_regbank

Overview:
- Parameterised AXI4-Lite slave register bank. It is the next generation of the fixed four-register custom IP.
- Provides NUM_RW read/write control registers with byte strobes, NUM_RO read-only status registers, per-register write pulses, and defined error responses for illegal accesses.
- Sits behind the block-design AXI interconnect. It is the standard front end for custom IP cores.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, AXI data width; legal values are 32 or 64.
- C_S_AXI_ADDR_WIDTH, 6, AXI byte-address width; must cover the whole register map.
- NUM_RW, 4, number of read/write registers; range 1..64.
- NUM_RO, 2, number of read-only status registers; range 0..64.
- NUM_IRQ, 8, number of interrupt sources; must be ≤ C_S_AXI_DATA_WIDTH. Used only with the optional feature.

Ports:
- ACLK  in  1  clock
- ARESET  in  1  asynchronous active-high reset
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
- S_AXI_AWPROT  in  3  ignored
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1 / 1  write-address handshake
- S_AXI_WDATA  in  DW  write data
- S_AXI_WSTRB  in  DW/8  byte strobes
- S_AXI_WVALID / S_AXI_WREADY  in / out  1 / 1  write-data handshake
- S_AXI_BRESP  out  2  write response
- S_AXI_BVALID / S_AXI_BREADY  out / in  1 / 1  write-response handshake
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
- S_AXI_ARPROT  in  3  ignored
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1 / 1  read-address handshake
- S_AXI_RDATA  out  DW  read data
- S_AXI_RRESP  out  2  read response
- S_AXI_RVALID / S_AXI_RREADY  out / in  1 / 1  read-data handshake
- ctrl_o  out  NUM_RW*DW  RW register contents; register k occupies bits [k*DW +: DW]
- wr_pulse_o  out  NUM_RW  one-cycle pulse per RW register written
- status_i  in  NUM_RO*DW  RO register sources; sampled at read time

Behaviour:
- Reset:
  - All AXI ready and valid outputs are 0; BRESP, RRESP and RDATA are 0.
  - ctrl_o is 0 and wr_pulse_o is 0.
  - Both FSMs return to IDLE immediately; any in-flight transaction is dropped.
- Address decode:
  - Word index idx = ADDR[AW-1:log2(DW/8)]; low byte-offset bits are ignored.
  - idx < NUM_RW: RW register.
  - NUM_RW ≤ idx < NUM_RW+NUM_RO: RO register.
  - Anything else is unmapped.
- Write FSM, states W_IDLE → W_ACK → W_RESP:
  - W_IDLE: when AWVALID and WVALID are both high in cycle N, go to W_ACK. Address and data are captured at the end of cycle N.
  - W_ACK (cycle N+1): AWREADY=WREADY=1 for exactly this one cycle.
    - RW target: apply bytes whose WSTRB bit is 1; other bytes are unchanged. The new value is visible on ctrl_o at N+2.
    - wr_pulse_o[idx]=1 in cycle N+2, even if WSTRB=0.
  - W_RESP: BVALID=1 from N+2 and held until BREADY.
    - BRESP = OKAY for RW, SLVERR for RO (no state change), DECERR for unmapped.
  - Return to W_IDLE the cycle after BVALID&&BREADY.
  - AWVALID alone or WVALID alone never advances the FSM.
- Read FSM, states R_IDLE → R_ACK → R_DATA:
  - R_IDLE: when ARVALID is high in cycle N, go to R_ACK.
  - R_ACK (cycle N+1): ARREADY=1; RDATA and RRESP are registered.
  - R_DATA: RVALID=1 from N+2; RDATA and RRESP are held stable until RREADY.
    - RW or RO target: RRESP = OKAY.
    - Unmapped target: RRESP = DECERR and RDATA = 0.
- Concurrency:
  - The read and write FSMs are independent.
  - If a write commits in the same cycle the read samples, the read returns the pre-write value.
- Outstanding transactions: at most one write and one read; no pipelining.
- Throughput: one write every 3 cycles and one read every 3 cycles when the master is always ready.

Optional Feature:
- Macro AXIL_REGBANK_IRQ_EN. With the macro defined, two extra registers follow the RO registers, plus two ports: irq_src_i (in, NUM_IRQ) and irq_o (out, 1).
  - IRQ_STATUS at idx NUM_RW+NUM_RO, write-1-to-clear.
  - IRQ_ENABLE at idx NUM_RW+NUM_RO+1, read/write.
- STATUS bit i is set on a rising edge of irq_src_i[i], which is edge-detected internally.
- If a set and a W1C clear hit the same bit in the same cycle, the set wins.
- irq_o = |(STATUS & ENABLE), registered; it is 0 at reset.
- Without the macro: those indices are unmapped (DECERR) and the IRQ ports do not exist.

Decomposition:
- Package axil_regbank_pkg:
  - Response constants: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - FSM state enums for the write and read FSMs.
  - A decode-result enum: RW, RO, IRQ_STAT, IRQ_EN, UNMAPPED.
- One sub-module, axil_regbank_decode: a combinational index-to-region decoder, instantiated once each for the write and read paths.

Test Plan:
- Sequential write/read, NUM_RW=4: write 0x1..0x4 to 0x0,0x4,0x8,0xC → BRESP OKAY; reads return 0x1..0x4 with RRESP OKAY; wr_pulse_o pulses 1,2,4,8 in turn.
- Byte strobes: reg0=0xAABBCCDD, then write 0x11223344 with WSTRB=4'b0101 → ctrl_o[31:0]=0xAA22CC44.
- Error responses: write 0xFFFF to an RO index → SLVERR and status unchanged; read idx 15 → DECERR with RDATA=0.
- Handshake skew: WVALID asserted 5 cycles after AWVALID → both readies pulse together once; BVALID held across 4 cycles of BREADY=0.
- Reset mid-write: assert ARESET in W_RESP → BVALID=0 and ctrl_o=0 immediately; the next write after release completes normally.
- With AXIL_REGBANK_IRQ_EN:
  - Set ENABLE=0x01 and pulse irq_src_i[0] → irq_o=1.
  - W1C 0x01 in the same cycle as a new edge → STATUS bit stays 1.
